rv32_seq_ctrl: RTL and testbench
================================

# rv32_seq_ctrl

Multi-cycle sequencer for the RV32E single-issue datapath. Fetches each instruction over a valid/ack handshake, holds it in an instruction register, and issues the per-instruction strobes: register-file write enable, then PC update. Detects halt instructions and fetch timeouts, and optionally keeps cycle and retired-instruction counters. Sits between the instruction memory port and the control unit, register file and PC.

## Interface
Parameters:
- FETCH_TIMEOUT, default 16: maximum cycles `ifetch_req` may stay high without `ifetch_ack` before the block faults; legal range 1..255.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ifetch_req  out  1  fetch request to instruction memory.
- ifetch_ack  in  1  instruction memory accepts and returns `inst_in` in the same cycle.
- inst_in  in  32  fetched instruction word.
- inst_ir  out  32  latched instruction register fed to the control unit.
- halt_inst  in  1  decoded halt (ebreak) flag from the control unit, based on `inst_ir`.
- stall  in  1  external hold; sampled only in EXEC.
- reg_we_en  out  1  one-cycle strobe; the register file writes when this is high and the decoded `wen` is high.
- pc_we  out  1  one-cycle strobe; PC loads its next value.
- halted  out  1  sticky; high once a halt is reached.
- fetch_err  out  1  sticky; high after a fetch timeout.
- state_o  out  3  current state encoding, for debug.
- cycle_cnt  out  CNT_W  active-cycle counter.
- instret_cnt  out  CNT_W  retired-instruction counter.

## Operation
State encodings: IDLE=0, FETCH=1, EXEC=2, WB=3, PCUP=4, HALT=5, ERR=6.

Transitions:
- IDLE -> FETCH unconditionally.
- FETCH: `ifetch_req`=1. On `ifetch_ack`, capture `inst_in` into `inst_ir` and go to EXEC. Otherwise increment the timeout counter; when it reaches FETCH_TIMEOUT, go to ERR.
- EXEC: `inst_ir` is stable and the datapath settles.
  - If `halt_inst`=1, go to HALT. No write-back and no PC update occur.
  - Else if `stall`=1, stay in EXEC.
  - Else go to WB.
- WB: `reg_we_en`=1, then go to PCUP.
- PCUP: `pc_we`=1, increment `instret_cnt`, then go to FETCH.
- HALT: `halted`=1. Absorbing state; only `rst` exits it.
- ERR: `fetch_err`=1. Absorbing state; only `rst` exits it.

Other rules:
- The timeout counter clears on entry to FETCH and on ack.
- `inst_ir` changes only on a FETCH ack.
- `ifetch_ack` outside FETCH is ignored.
- `halt_inst` and `stall` high together in EXEC: halt wins.
- `reg_we_en` and `pc_we` are never high in the same cycle.

## Timing
- Reset values: state=IDLE, `inst_ir`=0x00000013 (nop), every strobe 0, `halted`=0, `fetch_err`=0, counters 0.
- `rst` asserted in any state, including mid-FETCH, HALT or ERR, returns the block to IDLE on the next edge. An outstanding fetch is abandoned.
- With the ack in the same cycle as the request (ack in cycle N), an instruction occupies 4 cycles:
  - FETCH in cycle N.
  - EXEC in N+1.
  - WB in N+2.
  - PCUP in N+3.
  - Next `ifetch_req` in N+4.
- The first `ifetch_req` after reset release comes 1 cycle later (the IDLE cycle).
- Each stall cycle adds exactly one cycle to EXEC.
- `cycle_cnt` increments every cycle the state is not IDLE, HALT or ERR. It wraps modulo 2^CNT_W.
- `instret_cnt` increments in the PCUP cycle. It wraps modulo 2^CNT_W.

## Configuration
- `RV32_SEQ_PERF_EN` defined: `cycle_cnt` and `instret_cnt` are implemented as described above.
- `RV32_SEQ_PERF_EN` undefined: no counter registers exist, and both outputs are tied to 0. All other behaviour is identical.

## Test plan
- Zero-wait fetch: ack held high, three non-halt instructions.
  - `ifetch_req` is asserted in cycles 1, 5 and 9 after reset release.
  - `reg_we_en` pulses in cycles 3, 7 and 11; `pc_we` pulses in cycles 4, 8 and 12.
  - `instret_cnt`=3 after cycle 12.
- Wait states: ack arrives 5 cycles after the request.
  - `inst_ir` updates only on the ack edge.
  - `fetch_err` stays 0; the WB strobe follows 2 cycles after the ack.
- Timeout: FETCH_TIMEOUT=4, ack never arrives.
  - State enters ERR (6) after the 4th unacknowledged request cycle.
  - `fetch_err`=1 and `ifetch_req`=0; `cycle_cnt` freezes.
- Halt: `inst_ir`=0x00100073 with `halt_inst`=1.
  - State goes to HALT; `reg_we_en` and `pc_we` never pulse.
  - `halted` stays 1 for 20+ cycles despite toggling ack.
- Stall: `stall` held 3 cycles in EXEC.
  - The WB strobe is delayed by exactly 3 cycles.
  - `cycle_cnt` is 3 higher than in the no-stall run.
  - `halt_inst` and `stall` together cause HALT.
- Reset mid-operation: `rst` asserted during a FETCH wait and during HALT.
  - All outputs return to their reset values the next cycle.
  - `ifetch_req` reasserts 1 cycle after release.
  - With `RV32_SEQ_PERF_EN` undefined, both counters read 0 throughout.

Source files
------------

// File: rtl/rv32_seq_ctrl.sv
// rv32_seq_ctrl: multi-cycle fetch/execute/write-back/PC-update sequencer for the RV32E datapath.
// Optional performance counters are enabled by defining RV32_SEQ_PERF_EN.
`default_nettype none

module rv32_seq_ctrl #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifetch_req,
    input  logic             ifetch_ack,
    input  logic [31:0]      inst_in,
    output logic [31:0]      inst_ir,
    input  logic             halt_inst,
    input  logic             stall,
    output logic             reg_we_en,
    output logic             pc_we,
    output logic             halted,
    output logic             fetch_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_PCUP  = 3'd4,
        S_HALT  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  to_q, to_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= NOP_INST;
            to_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                to_d    = 8'd0;
            end
            S_FETCH: begin
                if (ifetch_ack) begin
                    ir_d    = inst_in;
                    to_d    = 8'd0;
                    state_d = S_EXEC;
                end else begin
                    // This cycle is the FETCH_TIMEOUT-th unanswered request.
                    to_d = to_q + 8'd1;
                    if (to_q == TO_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_EXEC: begin
                if (halt_inst) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    state_d = S_WB;
                end
            end
            S_WB:   state_d = S_PCUP;
            S_PCUP: begin
                state_d = S_FETCH;
                to_d    = 8'd0;
            end
            S_HALT: state_d = S_HALT;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign ifetch_req = (state_q == S_FETCH);
    assign reg_we_en  = (state_q == S_WB);
    assign pc_we      = (state_q == S_PCUP);
    assign halted     = (state_q == S_HALT);
    assign fetch_err  = (state_q == S_ERR);
    assign state_o    = state_q;
    assign inst_ir    = ir_q;

`ifdef RV32_SEQ_PERF_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;
    logic             active;

    assign active = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                    (state_q == S_WB)    || (state_q == S_PCUP);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (active) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (state_q == S_PCUP) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32_seq_ctrl.sv
// tb_rv32_seq_ctrl: directed stimulus with a cycle-level reference model and literal spot checks.
`default_nettype none

module tb_rv32_seq_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef RV32_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] inst = NOP;
    logic        halt_inst;

    logic        req, we, pc, hl, ferr;
    logic [31:0] ir, cyc, ret;
    logic [2:0]  st;

    logic        t_req, t_we, t_pc, t_hl, t_err;
    logic [31:0] t_ir, t_cyc, t_ret;
    logic [2:0]  t_st;

    // Stand-in for the control unit's ebreak decode of the instruction register.
    assign halt_inst = (ir == EBREAK);

    rv32_seq_ctrl dut (
        .clk(clk), .rst(rst), .ifetch_req(req), .ifetch_ack(ack), .inst_in(inst),
        .inst_ir(ir), .halt_inst(halt_inst), .stall(stall), .reg_we_en(we), .pc_we(pc),
        .halted(hl), .fetch_err(ferr), .state_o(st), .cycle_cnt(cyc), .instret_cnt(ret)
    );

    rv32_seq_ctrl #(.FETCH_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .ifetch_req(t_req), .ifetch_ack(1'b0), .inst_in(32'h0),
        .inst_ir(t_ir), .halt_inst(1'b0), .stall(1'b0), .reg_we_en(t_we), .pc_we(t_pc),
        .halted(t_hl), .fetch_err(t_err), .state_o(t_st), .cycle_cnt(t_cyc), .instret_cnt(t_ret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: spec-level state number, IR, timeout count and counters.
    int          m_st = 0;
    int          m_to = 0;
    logic [31:0] m_ir = NOP;
    logic [31:0] m_cyc = 0, m_ret = 0;
    bit          m_valid = 0;
    logic        s_ack = 0, s_halt = 0, s_stall = 0;
    logic [31:0] s_inst = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0; m_to <= 0; m_ir <= NOP; m_cyc <= 0; m_ret <= 0; m_valid <= 1'b1;
        end else begin
            if (m_st >= 1 && m_st <= 4) m_cyc <= m_cyc + 1;
            case (m_st)
                0: begin m_st <= 1; m_to <= 0; end
                1: if (s_ack) begin
                        m_ir <= s_inst; m_to <= 0; m_st <= 2;
                    end else begin
                        m_to <= m_to + 1;
                        if (m_to + 1 >= 16) m_st <= 6;
                    end
                2: if (s_halt) m_st <= 5; else if (!s_stall) m_st <= 3;
                3: m_st <= 4;
                4: begin m_ret <= m_ret + 1; m_to <= 0; m_st <= 1; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model", {st, req, we, pc, hl, ferr, ir, cyc, ret},
                {3'(m_st), m_st == 1, m_st == 3, m_st == 4, m_st == 5, m_st == 6, m_ir,
                 PERF ? m_cyc : 32'd0, PERF ? m_ret : 32'd0});
        end
        s_ack <= ack; s_halt <= halt_inst; s_stall <= stall; s_inst <= inst;
    end

    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; stall = 1'b0; inst = NOP;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, st, 3'd0);
        chk({tag, "_strobes"}, {req, we, pc, hl, ferr}, 5'b0);
        chk({tag, "_ir"}, ir, NOP);
        chk({tag, "_cnt"}, {cyc, ret}, 64'd0);
        chk({tag, "_to_state"}, {t_st, t_err}, 4'd0);
    endtask

    task automatic rst_now_and_release(input string tag);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_reset_vals(tag);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk({tag, "_req_c0"}, req, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_req_c1"}, req, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        @(negedge clk);
        chk_reset_vals("reset");

        // Zero-wait fetch, three instructions
        ack = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            inst = 32'h0000_0093 | (32'(k) << 20);
            @(negedge clk);
            if (k <= 12) begin
                chk($sformatf("zw_req_c%0d", k), req, (k == 1 || k == 5 || k == 9));
                chk($sformatf("zw_we_c%0d", k), we, (k == 3 || k == 7 || k == 11));
                chk($sformatf("zw_pc_c%0d", k), pc, (k == 4 || k == 8 || k == 12));
            end
            if (k == 6) chk("zw_ir_c6", ir, 32'h0050_0093);
            if (k == 13) begin
                chk("zw_instret", ret, PERF ? 32'd3 : 32'd0);
                chk("zw_cycle", cyc, PERF ? 32'd12 : 32'd0);
            end
        end

        // Wait states (ack 5 cycles after request) alongside the timeout instance
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            ack  = (k == 6);
            inst = (k == 6) ? 32'h0070_0113 : 32'h0BAD_F013;
            @(negedge clk);
            if (k == 6) chk("ws_ir_hold", ir, NOP);
            if (k == 7) chk("ws_ir_load", ir, 32'h0070_0113);
            chk($sformatf("ws_we_c%0d", k), we, (k == 8));
            if (k == 10) chk("ws_ferr", ferr, 1'b0);
            if (k == 4) chk("to_st_c4", t_st, 3'd1);
            if (k == 5) begin
                chk("to_st_c5", t_st, 3'd6);
                chk("to_err_req", {t_err, t_req}, 2'b10);
                chk("to_cyc_c5", t_cyc, PERF ? 32'd4 : 32'd0);
            end
            if (k == 10) chk("to_cyc_frozen", {t_st, t_cyc}, {3'd6, PERF ? 32'd4 : 32'd0});
        end
        rst_now_and_release("rst_fetch");

        // Halt
        do_reset();
        ack = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            if (k == 1) inst = EBREAK;
            else begin
                ack  = k[0];
                inst = 32'h0000_0013 | ($urandom() & 32'hFFF0_0F80);
            end
            @(negedge clk);
            if (k >= 3) chk($sformatf("halt_c%0d", k), {st, hl, req}, {3'd5, 1'b1, 1'b0});
            chk($sformatf("halt_strobes_c%0d", k), {we, pc}, 2'b00);
            if (k == 27) chk("halt_cyc", cyc, PERF ? 32'd2 : 32'd0);
        end
        rst_now_and_release("rst_halt");

        // Stall, then halt+stall together
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            ack   = (k == 1 || k == 8);
            stall = (k >= 2 && k <= 4) || (k == 9);
            inst  = (k == 8) ? EBREAK : 32'h0020_0093;
            @(negedge clk);
            chk($sformatf("st_we_c%0d", k), we, (k == 6));
            chk($sformatf("st_pc_c%0d", k), pc, (k == 7));
            if (k == 8) chk("st_cyc", cyc, PERF ? 32'd7 : 32'd0);
            if (k == 10) chk("st_halt_wins", {st, hl}, {3'd5, 1'b1});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
